// File: rtl/div_32_seq_if.sv
// Operand/result bundle between the control unit and the sequential divider.
// The control unit is the master: it drives the start strobe and both operands
// and watches busy/done to stall and latch the 64-bit result into Z.
interface div_32_seq_if #(
  parameter int WIDTH = 32
);
  logic                   in_start;
  logic [WIDTH-1:0]       in_a;
  logic [WIDTH-1:0]       in_b;
  logic [2*WIDTH-1:0]     out_result;
  logic                   out_busy;
  logic                   out_done;
  logic                   out_div_zero;

  modport master (
    output in_start, in_a, in_b,
    input  out_result, out_busy, out_done, out_div_zero
  );

  modport slave (
    input  in_start, in_a, in_b,
    output out_result, out_busy, out_done, out_div_zero
  );
endinterface

// File: rtl/div_32_seq.sv
// Sequential signed divider for the Mini-SRC div opcode.
// Restoring radix-2 on magnitudes, one quotient bit per cycle, followed by a
// sign-fixup cycle. Result layout matches the ALU: {remainder, quotient}.
// Quotient truncates toward zero; remainder takes the dividend's sign.
// Divide by zero returns quotient = all ones, remainder = dividend, flag set.
module div_32_seq #(
  parameter int WIDTH = 32
) (
  input  logic           in_clk,
  input  logic           in_rst,
  div_32_seq_if.slave    bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, DIVIDE, FIXUP, DONE} state_t;

  state_t               state_q;
  logic                 sign_quo_q;
  logic                 sign_rem_q;
  logic [WIDTH-1:0]     quo_q;
  logic [WIDTH-1:0]     divisor_q;
  logic [WIDTH-1:0]     dividend_q;
  logic [WIDTH:0]       rem_q;
  logic [CW-1:0]        count_q;
  logic [2*WIDTH-1:0]   result_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 div_zero_q;

  logic [WIDTH-1:0]     a_abs_d;
  logic [WIDTH-1:0]     b_abs_d;
  logic [WIDTH+1:0]     trial_d;
  logic [WIDTH:0]       rem_d;
  logic [WIDTH-1:0]     quo_d;
  logic [WIDTH-1:0]     quo_fix_d;
  logic [WIDTH-1:0]     rem_fix_d;
  logic                 div_zero_d;

  // Operand magnitudes, one restoring step, and the sign/zero fixup values.
  always_comb begin
    a_abs_d = bus.in_a[WIDTH-1] ? -bus.in_a : bus.in_a;
    b_abs_d = bus.in_b[WIDTH-1] ? -bus.in_b : bus.in_b;

    // Shifted remainder minus divisor, two guard bits so the sign is exact
    // even for a 2^(WIDTH-1) divisor magnitude.
    trial_d = {rem_q, quo_q[WIDTH-1]} - {2'b00, divisor_q};
    if (!trial_d[WIDTH+1]) begin
      rem_d = trial_d[WIDTH:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end

    // |b| is zero only when b itself is zero, so the magnitude register
    // doubles as the divide-by-zero detector.
    div_zero_d = (divisor_q == '0);
    if (div_zero_d) begin
      quo_fix_d = '1;
      rem_fix_d = dividend_q;
    end else begin
      quo_fix_d = sign_quo_q ? -quo_q : quo_q;
      rem_fix_d = sign_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    end
  end

  // Control FSM with registered outputs; reset abandons any divide in flight.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q    <= IDLE;
      sign_quo_q <= 1'b0;
      sign_rem_q <= 1'b0;
      quo_q      <= '0;
      divisor_q  <= '0;
      dividend_q <= '0;
      rem_q      <= '0;
      count_q    <= '0;
      result_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.in_start) begin
            sign_quo_q <= bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1];
            sign_rem_q <= bus.in_a[WIDTH-1];
            quo_q      <= a_abs_d;
            divisor_q  <= b_abs_d;
            dividend_q <= bus.in_a;
            rem_q      <= '0;
            count_q    <= '0;
            div_zero_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= DIVIDE;
          end else begin
            state_q    <= IDLE;
          end
        end
        DIVIDE: begin
          rem_q   <= rem_d;
          quo_q   <= quo_d;
          count_q <= count_q + 1'b1;
          if (count_q == LAST) begin
            state_q <= FIXUP;
          end
        end
        FIXUP: begin
          result_q   <= {rem_fix_d, quo_fix_d};
          div_zero_q <= div_zero_d;
          busy_q     <= 1'b0;
          done_q     <= 1'b1;
          state_q    <= DONE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.out_result   = result_q;
  assign bus.out_busy     = busy_q;
  assign bus.out_done     = done_q;
  assign bus.out_div_zero = div_zero_q;
endmodule

// File: doc/div_32_seq.md
# div_32_seq

Sequential signed 32-bit divider implementing Mini-SRC opcode 1001 (div). The combinational ALU leaves that opcode unimplemented and returns 0. This block sits beside the ALU on the same operand buses (A, B) and produces the same 64-bit result format, so the control unit can steer it into the Z register: HI = remainder, LO = quotient. The control unit starts a divide, stalls on `out_busy`, and latches `out_result` into Z when `out_done` pulses.

## Interface
- `WIDTH`, default 32: operand width. Result is 2*WIDTH wide and an iteration takes WIDTH cycles.
- `in_clk`  input  1: clock. All state changes on the rising edge.
- `in_rst`  input  1: reset, asynchronous and active-high.
- `in_start`  input  1: request a divide; sampled on the rising edge.
- `in_a`  input  WIDTH: dividend (signed, two's complement); sampled with `in_start`.
- `in_b`  input  WIDTH: divisor (signed); sampled with `in_start`.
- `out_result`  output  2*WIDTH: {remainder, quotient}. Held until the next accepted start.
- `out_busy`  output  1: high while a divide is in progress.
- `out_done`  output  1: one-cycle pulse when `out_result` becomes valid.
- `out_div_zero`  output  1: divisor was zero for the current result. Held alongside `out_result`.

## Operation
- **FSM states:** IDLE, DIVIDE, FIXUP, DONE.
- **IDLE / DONE:** if `in_start` = 1, the block:
  - latches sign_q = a[MSB]^b[MSB] and sign_r = a[MSB];
  - loads |a| into the quotient shift register and |b| into the divisor register;
  - clears the partial remainder (WIDTH+1 bits) and the iteration counter;
  - clears `out_div_zero`;
  - goes to DIVIDE.
  Otherwise DONE returns to IDLE and IDLE stays put.
- **DIVIDE:** one restoring radix-2 step per cycle:
  - shift {rem, quo} left by one;
  - trial = rem − divisor;
  - if trial ≥ 0: rem = trial and quo[0] = 1; else quo[0] = 0.
  - After WIDTH steps (counter = WIDTH−1 on the last step), go to FIXUP.
- **FIXUP:**
  - quotient = sign_q ? −quo : quo; remainder = sign_r ? −rem : rem. Both are truncated to WIDTH bits. This gives truncation toward zero, with remainder sign = dividend sign.
  - If the latched divisor = 0, override the result: quotient = all ones, remainder = dividend (original signed value), `out_div_zero` = 1.
  - Register into `out_result`, then go to DONE.
- **Overflow:** 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0, with no flag. This is the natural wrap; no special case is needed.
- **`in_start` while in DIVIDE or FIXUP:** ignored. Operands are not re-sampled.
- **Operand changes after acceptance:** `in_a` and `in_b` may change freely; the block uses only the latched copies.
- **Outputs:**
  - `out_busy` = 1 in DIVIDE and FIXUP.
  - `out_done` = 1 only in DONE.
  - `out_result` and `out_div_zero` change only on the FIXUP→DONE edge, or when a new start is accepted (flag clears only).
- **Reset (asynchronous, any state):**
  - state = IDLE;
  - `out_result` = 0;
  - `out_busy` = 0, `out_done` = 0, `out_div_zero` = 0;
  - all internal registers = 0.
  - A divide in flight is abandoned and produces no `out_done`.

## Timing
- Start accepted at edge E0.
- `out_busy` rises after E0.
- DIVIDE occupies edges E1..E_WIDTH.
- FIXUP writes the result at edge E_WIDTH+1. At that edge `out_busy` falls and `out_done` rises.
- `out_done` falls at E_WIDTH+2, unless a new start is accepted at that edge; even then `out_done` still falls, because the next state is DIVIDE.
- Latency is fixed at WIDTH+1 cycles from the start edge to a valid result (33 for WIDTH = 32), independent of operand values, including divide-by-zero.
- Back-to-back throughput: one divide per WIDTH+2 cycles when `in_start` is asserted during DONE.
- No combinational path from inputs to outputs.

## Test plan
- **Positive operands:** a = 100, b = 7, start for one cycle → after 33 cycles `out_done` pulses once with `out_result` = 0x00000002_0000000E; `out_busy` is high for exactly 33 cycles; `out_div_zero` = 0.
- **Mixed signs:**
  - a = −100, b = 7 → `out_result` = 0xFFFFFFFE_FFFFFFF2.
  - a = 100, b = −7 → `out_result` = 0x00000002_FFFFFFF2.
- **Divide by zero:** a = 7, b = 0 → `out_result` = 0x00000007_FFFFFFFF and `out_div_zero` = 1, with the same 33-cycle latency. A following 9/3 clears the flag at its start and yields 0x00000000_00000003.
- **Overflow:** a = 0x80000000, b = 0xFFFFFFFF → `out_result` = 0x00000000_80000000 with no flag.
- **Start during busy:** start 100/7, re-assert start with 50/5 at cycle 10 → single `out_done` at cycle 33 with the 100/7 result. Start 50/5 during DONE → `out_done` again 33 cycles later with 0x00000000_0000000A.
- **Reset mid-operation:** assert `in_rst` asynchronously at cycle 15 of a divide → all outputs 0 immediately; no `out_done`. After release, 100/7 completes normally.
